// File: rtl/yuv_rgb_pkg.sv
// Shared definitions for the YUV->RGB converter and its memory master.
// Holds the BT.601 full-range Q8 coefficients, the rounding and chroma
// offsets, the master FSM state type and the 8-bit clamp helper.
package yuv_rgb_pkg;

  localparam int DATA_W = 8;   // Y/U/V and per-channel RGB width
  localparam int COEF_W = 18;  // stage-2 product width
  localparam int CH_W   = 11;  // stage-3 channel width before clamping
  localparam int Q_FRAC = 8;   // fractional bits of the coefficients

  localparam int K_RV   = 359;
  localparam int K_GU   = 88;
  localparam int K_GV   = 183;
  localparam int K_BU   = 454;
  localparam int ROUND  = 128;
  localparam int OFFSET = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Saturate a signed channel value to the 0..255 range.
  function automatic logic [7:0] clamp_u8(input logic signed [CH_W-1:0] x);
    if (x < 0) begin
      return 8'd0;
    end else if (x > 11'sd255) begin
      return 8'hFF;
    end else begin
      return x[7:0];
    end
  endfunction

endpackage

// File: rtl/yuv2rgb_pipe.sv
// Three-stage YUV -> RGB888 datapath (BT.601 full range, Q8 fixed point).
// A pixel presented with i_vld=1 appears on o_rgb with o_vld=1 three clocks
// later. o_rgb only changes on valid pixels, so bubbles leave it holding.
// Ports:
//   clk, rst     clock, synchronous active-high reset (valid bits, o_rgb)
//   i_vld        input pixel valid
//   i_y/i_u/i_v  luma and chroma bytes
//   o_inflight   a pixel occupies stage 1 or stage 2
//   o_vld        stage-3 valid (output pixel strobe)
//   o_rgb        {R,G,B}
module yuv2rgb_pipe
  import yuv_rgb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_vld,
  input  logic [DATA_W-1:0]     i_y,
  input  logic [DATA_W-1:0]     i_u,
  input  logic [DATA_W-1:0]     i_v,
  output logic                  o_inflight,
  output logic                  o_vld,
  output logic [3*DATA_W-1:0]   o_rgb
);

  logic signed [DATA_W:0]   w_ud;
  logic signed [DATA_W:0]   w_vd;
  logic signed [COEF_W-1:0] w_rt;
  logic signed [COEF_W-1:0] w_gt;
  logic signed [COEF_W-1:0] w_bt;
  logic signed [CH_W-1:0]   w_r;
  logic signed [CH_W-1:0]   w_g;
  logic signed [CH_W-1:0]   w_b;

  logic                     r_vld_p0;
  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic [DATA_W-1:0]        r_y_p0;
  logic [DATA_W-1:0]        r_y_p1;
  logic signed [DATA_W:0]   r_ud_p0;
  logic signed [DATA_W:0]   r_vd_p0;
  logic signed [COEF_W-1:0] r_rt_p1;
  logic signed [COEF_W-1:0] r_gt_p1;
  logic signed [COEF_W-1:0] r_bt_p1;
  logic [3*DATA_W-1:0]      r_rgb_p2;

  // Stage 1: centre the chroma around zero
  assign w_ud = (DATA_W+1)'($signed({1'b0, i_u}) - OFFSET);
  assign w_vd = (DATA_W+1)'($signed({1'b0, i_v}) - OFFSET);

  // Stage 2: Q8 products with the rounding constant folded in
  assign w_rt = COEF_W'(K_RV * int'(r_vd_p0) + ROUND);
  assign w_gt = COEF_W'(K_GU * int'(r_ud_p0) + K_GV * int'(r_vd_p0) + ROUND);
  assign w_bt = COEF_W'(K_BU * int'(r_ud_p0) + ROUND);

  // Stage 3: arithmetic shift floors the Q8 term before adding luma
  assign w_r = CH_W'(int'(r_y_p1) + int'(r_rt_p1 >>> Q_FRAC));
  assign w_g = CH_W'(int'(r_y_p1) - int'(r_gt_p1 >>> Q_FRAC));
  assign w_b = CH_W'(int'(r_y_p1) + int'(r_bt_p1 >>> Q_FRAC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_rgb_p2 <= '0;
    end else begin
      r_vld_p0 <= i_vld;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_rgb_p2 <= {clamp_u8(w_r), clamp_u8(w_g), clamp_u8(w_b)};
      end
    end
  end

  always_ff @(posedge clk) begin
    r_y_p0  <= i_y;
    r_ud_p0 <= w_ud;
    r_vd_p0 <= w_vd;
    r_y_p1  <= r_y_p0;
    r_rt_p1 <= w_rt;
    r_gt_p1 <= w_gt;
    r_bt_p1 <= w_bt;
  end

  assign o_inflight = r_vld_p0 | r_vld_p1;
  assign o_vld      = r_vld_p2;
  assign o_rgb      = r_rgb_p2;

endmodule

// File: rtl/yuv2rgb_mem_master.sv
// Memory master that sweeps a frame of YUV addresses, converts each pixel
// to RGB888 through yuv2rgb_pipe and writes the results in address order.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 frame request, honoured only when idle
//   pause                 suppresses new reads while high
//   busy                  frame in progress (RUN or DRAIN)
//   done                  one-cycle pulse after the last pixel write
//   mem_addr, mem_read    read address and strobe (data returns same cycle)
//   y_data/u_data/v_data  pixel bytes for mem_addr
//   rgb, mem_write        converted pixel and its write strobe
module yuv2rgb_mem_master
  import yuv_rgb_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                FRAME_PIXELS = 4194304,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [7:0]        y_data,
  input  logic [7:0]        u_data,
  input  logic [7:0]        v_data,
  output logic [23:0]       rgb,
  output logic              mem_write
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic              w_mem_read;
  logic              w_busy;
  logic              w_done;
  logic              w_inflight;
  logic              w_pipe_vld;
  logic [23:0]       w_pipe_rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mem_read  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy     = 1'b1;
        w_mem_read = !pause;
        if (w_mem_read && (r_count == LAST)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        // The stage-3 pixel is written out this cycle, so only stages 1
        // and 2 need to be empty; done then follows the last write directly.
        if (!w_inflight) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else if (w_mem_read) begin
      r_addr  <= r_addr + ADDR_W'(1);
      r_count <= r_count + CNT_W'(1);
    end else if (r_state == ST_DONE) begin
      r_addr  <= BASE_ADDR;
    end
  end

  yuv2rgb_pipe u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (w_mem_read),
    .i_y        (y_data),
    .i_u        (u_data),
    .i_v        (v_data),
    .o_inflight (w_inflight),
    .o_vld      (w_pipe_vld),
    .o_rgb      (w_pipe_rgb)
  );

  assign busy      = w_busy;
  assign done      = w_done;
  assign mem_addr  = r_addr;
  assign mem_read  = w_mem_read;
  assign rgb       = w_pipe_rgb;
  assign mem_write = w_pipe_vld;

endmodule

// File: tb/tb_yuv2rgb_mem_master.sv
module tb_yuv2rgb_mem_master;

  localparam int          NA    = 8;
  localparam logic [31:0] BASEA = 32'hFFFF_FFFC;
  localparam logic [31:0] BASEB = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, pause_a, start_b;
  logic        busy_a, done_a, mem_read_a, mem_write_a;
  logic [31:0] mem_addr_a;
  logic [7:0]  y_a, u_a, v_a;
  logic [23:0] rgb_a;
  logic        busy_b, done_b, mem_read_b, mem_write_b;
  logic [31:0] mem_addr_b;
  logic [7:0]  y_b, u_b, v_b;
  logic [23:0] rgb_b;

  logic [7:0] my [16];
  logic [7:0] mu [16];
  logic [7:0] mv [16];

  assign y_a = my[mem_addr_a[3:0]];
  assign u_a = mu[mem_addr_a[3:0]];
  assign v_a = mv[mem_addr_a[3:0]];
  assign y_b = 8'h4C;
  assign u_b = 8'h55;
  assign v_b = 8'hFF;

  always #5 clk = ~clk;

  yuv2rgb_mem_master #(.ADDR_W(32), .FRAME_PIXELS(NA), .BASE_ADDR(BASEA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pause(pause_a),
    .busy(busy_a), .done(done_a), .mem_addr(mem_addr_a), .mem_read(mem_read_a),
    .y_data(y_a), .u_data(u_a), .v_data(v_a), .rgb(rgb_a), .mem_write(mem_write_a)
  );

  yuv2rgb_mem_master #(.ADDR_W(32), .FRAME_PIXELS(1), .BASE_ADDR(BASEB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(1'b0),
    .busy(busy_b), .done(done_b), .mem_addr(mem_addr_b), .mem_read(mem_read_b),
    .y_data(y_b), .u_data(u_b), .v_data(v_b), .rgb(rgb_b), .mem_write(mem_write_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Reference conversion written with plain integer floor division.
  function automatic int fdiv256(input int a);
    if (a >= 0) return a / 256;
    return -((-a + 255) / 256);
  endfunction

  function automatic logic [7:0] sat8(input int x);
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
  endfunction

  function automatic logic [23:0] conv(input int y, input int u, input int v);
    int r, g, b;
    r = y + fdiv256(359 * (v - 128) + 128);
    g = y - fdiv256(88 * (u - 128) + 183 * (v - 128) + 128);
    b = y + fdiv256(454 * (u - 128) + 128);
    return {sat8(r), sat8(g), sat8(b)};
  endfunction

  // Behavioural model of DUT A: frame timing, address order and pixel values.
  typedef struct {
    int          cyc;
    logic [23:0] rgb;
  } exp_t;

  exp_t        q[$];
  logic [23:0] got[$];
  int          cyc = 0;
  int          run_from = -1;
  int          done_cyc = -1;
  int          reads = 0;
  int          acc_cyc = 0;
  int          first_wr_cyc = 0;
  int          last_wr_cyc = 0;
  int          done_seen_cyc = 0;
  int          done_cnt = 0;
  bit          armed = 1'b0;
  logic [23:0] last_rgb = '0;

  always @(negedge clk) begin
    bit          in_frame, exp_read, exp_wr, exp_done;
    logic [31:0] ea;
    exp_t        e;
    cyc++;
    in_frame = (run_from >= 0) && (cyc >= run_from) && ((done_cyc < 0) || (cyc <= done_cyc));
    exp_done = in_frame && (cyc == done_cyc);
    exp_read = in_frame && (reads < NA) && !pause_a;
    exp_wr   = (q.size() > 0) && (q[0].cyc == cyc);
    if (armed) begin
      chk("busy", 32'(busy_a), 32'(in_frame && !exp_done));
      chk("done", 32'(done_a), 32'(exp_done));
      chk("mem_read", 32'(mem_read_a), 32'(exp_read));
      chk("mem_write", 32'(mem_write_a), 32'(exp_wr));
      if (!in_frame) chk("addr_idle", mem_addr_a, BASEA);
      else if (reads < NA) chk("addr_run", mem_addr_a, BASEA + 32'(reads));
      if (exp_wr) begin
        chk("rgb", 32'(rgb_a), 32'(q[0].rgb));
        last_rgb = q[0].rgb;
      end else begin
        chk("rgb_hold", 32'(rgb_a), 32'(last_rgb));
      end
    end
    if (exp_wr) void'(q.pop_front());
    if (mem_write_a === 1'b1) begin
      if (got.size() == 0) first_wr_cyc = cyc;
      got.push_back(rgb_a);
      last_wr_cyc = cyc;
    end
    if (done_a === 1'b1) begin
      done_cnt++;
      done_seen_cyc = cyc;
    end
    if (rst) begin
      run_from = -1;
      done_cyc = -1;
      reads    = 0;
      q.delete();
      last_rgb = '0;
      armed    = 1'b1;
    end else begin
      if (exp_read) begin
        ea    = BASEA + 32'(reads);
        e.cyc = cyc + 3;
        e.rgb = conv(int'(my[ea[3:0]]), int'(mu[ea[3:0]]), int'(mv[ea[3:0]]));
        q.push_back(e);
        reads++;
        if (reads == NA) done_cyc = cyc + 4;
      end
      if (exp_done) begin
        run_from = -1;
        done_cyc = -1;
      end else if (start_a && !in_frame) begin
        run_from = cyc + 1;
        reads    = 0;
        acc_cyc  = cyc;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1;
    start_a = 1'b0;
    pause_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 16; i++) begin
      my[i] = 8'h80;
      mu[i] = 8'h80;
      mv[i] = 8'h80;
    end
    tick(3);

    // Reset state
    chk("rst_addr", mem_addr_a, BASEA);
    chk("rst_rgb", 32'(rgb_a), 32'h0);
    chk("rst_outs", 32'({busy_a, done_a, mem_read_a, mem_write_a}), 32'h0);
    chk("rst_addr_b", mem_addr_b, BASEB);

    // Pin the reference model with hand-computed pixels
    chk("model_ff80ff", 32'(conv(255, 128, 255)), 32'hFFA4FF);
    chk("model_000000", 32'(conv(0, 0, 0)), 32'h008700);
    chk("model_4c55ff", 32'(conv(76, 85, 255)), 32'hFE0000);
    chk("model_grey", 32'(conv(128, 128, 128)), 32'h808080);

    rst = 1'b0;
    tick(2);

    // Frame of neutral grey
    got.delete();
    d0 = done_cnt;
    pulse_start_a();
    wait_done(d0 + 1, 100);
    chk("grey_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) chk("grey_pix", 32'(got[i]), 32'h808080);
    chk("first_latency", 32'(first_wr_cyc - acc_cyc), 32'd4);
    chk("done_after_last", 32'(done_seen_cyc - last_wr_cyc), 32'd1);
    tick(1);
    chk("busy_after", 32'(busy_a), 32'd0);
    tick(3);

    // Clamping pixels, pause after the second read, extra start while busy
    for (int i = 0; i < 16; i++) begin
      my[i] = 8'($urandom);
      mu[i] = 8'($urandom);
      mv[i] = 8'($urandom);
    end
    my[12] = 8'hFF; mu[12] = 8'h80; mv[12] = 8'hFF;
    my[13] = 8'h00; mu[13] = 8'h00; mv[13] = 8'h00;
    my[14] = 8'h4C; mu[14] = 8'h55; mv[14] = 8'hFF;
    got.delete();
    d0 = done_cnt;
    pulse_start_a();
    tick(2);
    pause_a = 1'b1;
    tick(1);
    @(negedge clk);
    chk("pause_addr_hold", mem_addr_a, 32'hFFFF_FFFE);
    chk("pause_no_read", 32'(mem_read_a), 32'd0);
    @(posedge clk);
    #1;
    tick(1);
    pause_a = 1'b0;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_done(d0 + 1, 100);
    chk("clamp_count", 32'(got.size()), 32'd8);
    if (got.size() >= 3) begin
      chk("clamp_r_high", 32'(got[0]), 32'hFFA4FF);
      chk("clamp_rb_low", 32'(got[1]), 32'h008700);
      chk("clamp_mixed", 32'(got[2]), 32'hFE0000);
    end
    tick(12);
    chk("single_done", 32'(done_cnt), 32'(d0 + 1));

    // Randomised frames with random pauses and stray start pulses
    for (int f = 0; f < 6; f++) begin
      int n;
      for (int i = 0; i < 16; i++) begin
        my[i] = 8'($urandom);
        mu[i] = 8'($urandom);
        mv[i] = 8'($urandom);
      end
      got.delete();
      d0 = done_cnt;
      pulse_start_a();
      n = 0;
      while (done_cnt == d0 && n < 200) begin
        pause_a = ($urandom_range(0, 2) == 0);
        start_a = ($urandom_range(0, 9) == 0);
        tick(1);
        n++;
      end
      pause_a = 1'b0;
      start_a = 1'b0;
      chk("rand_done", 32'(done_cnt), 32'(d0 + 1));
      chk("rand_count", 32'(got.size()), 32'd8);
      tick($urandom_range(1, 4));
    end

    // Reset two cycles after the fifth read
    got.delete();
    d0 = done_cnt;
    pulse_start_a();
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_outs", 32'({busy_a, done_a, mem_read_a, mem_write_a}), 32'h0);
    chk("midrst_rgb", 32'(rgb_a), 32'h0);
    chk("midrst_addr", mem_addr_a, BASEA);
    @(posedge clk);
    #1;
    tick(10);
    chk("midrst_writes", 32'(got.size()), 32'd4);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));
    got.delete();
    pulse_start_a();
    wait_done(d0 + 1, 100);
    chk("restart_count", 32'(got.size()), 32'd8);
    tick(3);

    // Single-pixel frame on the second instance
    start_b = 1'b1;
    @(negedge clk);
    chk("b_idle_read", 32'(mem_read_b), 32'd0);
    @(posedge clk);
    #1;
    start_b = 1'b0;
    @(negedge clk);
    chk("b_read", 32'(mem_read_b), 32'd1);
    chk("b_addr", mem_addr_b, BASEB);
    chk("b_busy_run", 32'(busy_b), 32'd1);
    @(negedge clk);
    chk("b_one_read", 32'(mem_read_b), 32'd0);
    chk("b_busy_drain", 32'(busy_b), 32'd1);
    @(negedge clk);
    chk("b_no_write_yet", 32'(mem_write_b), 32'd0);
    @(negedge clk);
    chk("b_write", 32'(mem_write_b), 32'd1);
    chk("b_rgb", 32'(rgb_b), 32'hFE0000);
    chk("b_no_done_yet", 32'(done_b), 32'd0);
    @(negedge clk);
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_write_once", 32'(mem_write_b), 32'd0);
    chk("b_busy_low", 32'(busy_b), 32'd0);
    @(negedge clk);
    chk("b_done_pulse", 32'(done_b), 32'd0);
    chk("b_addr_back", mem_addr_b, BASEB);
    chk("b_rgb_hold", 32'(rgb_b), 32'hFE0000);
    @(posedge clk);
    #1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/yuv2rgb_mem_master.md
Name: yuv2rgb_mem_master

Overview:
- Initiator side of the YUV-read / RGB-write memory interface used by the colour-conversion sims and hardware.
- Sweeps a frame of addresses and issues read strobes.
- Samples the returned Y/U/V bytes and converts them to RGB888 (BT.601 full-range, Q8 fixed point) in a 3-stage pipeline.
- Emits each pixel on rgb with a mem_write strobe, in address order.

Parameters:
- FRAME_PIXELS, 4194304: pixels per frame (addresses BASE_ADDR .. BASE_ADDR+FRAME_PIXELS-1).
- BASE_ADDR, 0: first address issued.
- ADDR_W, 32: width of mem_addr.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to process a frame; honoured only in IDLE.
- pause  in  1  flow control; while high, no new read is issued.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last pixel is written.
- mem_addr  out  ADDR_W  read address.
- mem_read  out  1  read strobe; memory returns data combinationally in the same cycle.
- y_data  in  8  luma for mem_addr.
- u_data  in  8  Cb for mem_addr.
- v_data  in  8  Cr for mem_addr.
- rgb  out  24  {R[23:16],G[15:8],B[7:0]}.
- mem_write  out  1  rgb valid strobe, one pixel per asserted cycle.

Behaviour:
- Reset values: all outputs 0, mem_addr=BASE_ADDR, FSM=IDLE, pixel counter 0, pipeline valid bits 0.
- FSM states are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 moves to RUN and loads mem_addr=BASE_ADDR, count=0.
  - start is ignored in every other state.
- RUN:
  - mem_read = !pause.
  - Each cycle with mem_read=1: y/u/v are captured into stage 1 with valid=1, then mem_addr and count increment.
  - pause=1 holds mem_addr and injects a bubble (valid=0).
  - When the read with count==FRAME_PIXELS-1 issues, the next state is DRAIN.
- DRAIN:
  - mem_read=0.
  - Stay until all pipeline valid bits are 0, then go to DONE.
- DONE: done=1 for one cycle, then IDLE; mem_addr returns to BASE_ADDR.
- Pipeline stage 1: register Y, Ud=U-128, Vd=V-128 (9-bit signed).
- Pipeline stage 2 products (18-bit signed):
  - r_t = 359*Vd + 128
  - g_t = 88*Ud + 183*Vd + 128
  - b_t = 454*Ud + 128
- Pipeline stage 3:
  - R = Y + (r_t>>>8)
  - G = Y - (g_t>>>8)
  - B = Y + (b_t>>>8)
  - Shifts are arithmetic, i.e. floor.
  - Each channel is computed at 11-bit signed width, clamped to 0..255, then registered onto rgb.
  - mem_write is the stage-3 valid.
- Latency: read issued in cycle t gives mem_write/rgb in cycle t+3. Throughput is 1 pixel/clk when pause=0.
- Bubbles propagate: mem_write stays low for paused slots, and rgb holds its previous value.
- pause high during DRAIN has no effect; in-flight pixels still complete.
- Address arithmetic wraps modulo 2^ADDR_W; no range check beyond the count.
- FRAME_PIXELS=1: RUN lasts one read cycle.
- rst asserted mid-frame:
  - Returns to the reset state next edge.
  - Flushes in-flight pixels; no mem_write follows.
  - No done pulse.

Decomposition:
- Shared package yuv_rgb_pkg holds:
  - coefficient constants K_RV=359, K_GU=88, K_GV=183, K_BU=454;
  - ROUND=128, OFFSET=128;
  - the FSM state enum;
  - a function clamp_u8.
- Natural sub-module yuv2rgb_pipe: the 3-stage datapath with valid in/out, reusable without the memory FSM.
- The top level holds the FSM, address/count logic and port glue.

Test Plan:
- Memory model all Y=U=V=0x80, FRAME_PIXELS=4, start -> 4 consecutive mem_write with rgb=0x808080, first at start+1+3 cycles, then done pulse 1 cycle after the last write, busy low after.
- Pixel (Y,U,V)=(0xFF,0x80,0xFF) -> rgb=0xFFA4FF (R clamps high). (0x00,0x00,0x00) -> rgb=0x008700 (R/B clamp low). (0x4C,0x55,0xFF) -> rgb=0xFE0000.
- FRAME_PIXELS=8, pause high for 3 cycles after 2nd read -> mem_addr holds BASE+2 during pause, exactly 8 writes in address order, no duplicates, done after the 8th.
- start pulsed again while busy -> ignored; one done only, mem_addr sequence unaffected.
- rst asserted 2 cycles after the 5th read -> all outputs 0 next edge, no further mem_write, no done; a new start then restarts at BASE_ADDR.
- FRAME_PIXELS=1 -> one mem_read, one mem_write 3 cycles later, done the following cycle.
